// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared widths, FSM state encoding and the address range helper for the
// two-master SRAM arbiter.
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int SEL_W      = 4;
    localparam int SRAM_WORDS = 1056;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // True when a word index falls outside the attached memory.
    function automatic logic word_out_of_range(input logic [ADDR_W-3:0] word,
                                               input int unsigned      words);
        return ({2'b00, word} >= words);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker. On a tie the master that was not granted last
// wins; last_gnt resets to 1 so master 0 wins the first tie.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per master
//   update     : commit the current grant as the new last_gnt
//   gnt[1:0]   : one-hot grant (zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_gnt;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (update) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares a single-port SRAM between the pipeline data port (m0) and the
// reconfiguration loader (m1). Each access runs IDLE -> ACCESS -> DONE; the
// memory pins are live only in ACCESS and the owner sees a one-cycle ack in
// DONE. Out-of-range word indices are acked with err = 1 and rdata = 0 and
// never enable the memory.
//   clk, rst_n              : clock, asynchronous active-low reset
//   mX_req/we/addr/sel/wdata: master request and qualifiers (X = 0, 1)
//   mX_ack/err/rdata        : registered completion, error and read data
//   sram_ce/we/addr/sel/wdata: registered memory pins
//   sram_rdata              : combinational memory read data
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int MEM_WORDS = SRAM_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [SEL_W-1:0]  m0_sel,
    input  logic [SEL_W-1:0]  m1_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [SEL_W-1:0]  sram_sel,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    arb_state_t        state_q, state_d;
    logic [1:0]        gnt;
    logic              grant;
    logic              win1;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [SEL_W-1:0]  win_sel;
    logic [DATA_W-1:0] win_wdata;
    logic              range_err;

    // Transaction latch: owner, error flag and read/write direction.
    logic              own_q;
    logic              err_q;
    logic              rd_q;

    logic              ce_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [SEL_W-1:0]  sel_d;
    logic [DATA_W-1:0] wdata_d;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({m1_req, m0_req}),
        .update (grant),
        .gnt    (gnt)
    );

    assign win1      = gnt[1];
    assign win_we    = win1 ? m1_we    : m0_we;
    assign win_addr  = win1 ? m1_addr  : m0_addr;
    assign win_sel   = win1 ? m1_sel   : m0_sel;
    assign win_wdata = win1 ? m1_wdata : m0_wdata;
    assign range_err = word_out_of_range(win_addr[ADDR_W-1:2], MEM_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next memory-pin values. The pins are registered, so
    // values computed in IDLE appear during ACCESS and the all-zero defaults
    // computed in ACCESS clear them for DONE.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        ce_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        sel_d   = '0;
        wdata_d = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ARB_ACCESS;
                    grant   = 1'b1;
                    if (!range_err) begin
                        ce_d    = 1'b1;
                        we_d    = win_we;
                        addr_d  = win_addr;
                        sel_d   = win_sel;
                        wdata_d = win_wdata;
                    end
                end
            end
            ARB_ACCESS: state_d = ARB_DONE;
            ARB_DONE:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_sel   <= '0;
            sram_wdata <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            sram_ce    <= ce_d;
            sram_we    <= we_d;
            sram_addr  <= addr_d;
            sram_sel   <= sel_d;
            sram_wdata <= wdata_d;
            if (grant) begin
                own_q <= win1;
                err_q <= range_err;
                rd_q  <= ~win_we;
            end
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            // Leaving ACCESS: ack the owner and capture read data. Writes
            // leave the owner's rdata untouched.
            if (state_q == ARB_ACCESS) begin
                if (!own_q) begin
                    m0_ack <= 1'b1;
                    m0_err <= err_q;
                    if (err_q) begin
                        m0_rdata <= '0;
                    end else if (rd_q) begin
                        m0_rdata <= sram_rdata;
                    end
                end else begin
                    m1_ack <= 1'b1;
                    m1_err <= err_q;
                    if (err_q) begin
                        m1_rdata <= '0;
                    end else if (rd_q) begin
                        m1_rdata <= sram_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Drives sram_arbiter from two transaction queues, models the attached SRAM,
// and checks every cycle against a transaction-level reference: expected
// owner order from the round-robin rule, ack timing (2 cycles to the first
// ack, 3 between back-to-back acks), memory pins, err, and read data taken
// from a shadow copy of memory contents.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int WORDS = SRAM_WORDS;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } txn_t;

    logic        clk, rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_ce, sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic [3:0]  sram_sel;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];
    txn_t        q0[$], q1[$];
    logic [1:0]  ack_log[$];
    logic [31:0] hold [2];
    int          last_g;
    int          n_checks, n_fail;

    sram_arbiter #(.MEM_WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_sel(m0_sel), .m1_sel(m1_sel),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_sel(sram_sel), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: combinational read, byte-lane write at posedge.
    always_comb begin
        sram_rdata = '0;
        if (sram_ce && int'(sram_addr[31:2]) < WORDS) sram_rdata = mem[int'(sram_addr[31:2])];
    end

    always @(posedge clk) begin
        if (sram_ce && sram_we && int'(sram_addr[31:2]) < WORDS) begin
            for (int b = 0; b < 4; b++)
                if (sram_sel[b]) mem[int'(sram_addr[31:2])][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int m, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.sel = sel; t.wdata = wdata;
        if (m == 1) q1.push_back(t); else q0.push_back(t);
    endtask

    task automatic drive();
        m0_req = (q0.size() > 0);
        m1_req = (q1.size() > 0);
        if (m0_req) begin
            m0_we = q0[0].we; m0_addr = q0[0].addr; m0_sel = q0[0].sel; m0_wdata = q0[0].wdata;
        end
        if (m1_req) begin
            m1_we = q1[0].we; m1_addr = q1[0].addr; m1_sel = q1[0].sel; m1_wdata = q1[0].wdata;
        end
    endtask

    // Round-robin rule: a lone requester wins; on a tie the one not granted last.
    task automatic select(output int owner);
        if (q0.size() > 0 && q1.size() > 0) owner = 1 - last_g;
        else if (q0.size() > 0)             owner = 0;
        else if (q1.size() > 0)             owner = 1;
        else                                owner = -1;
        if (owner >= 0) last_g = owner;
    endtask

    task automatic run_stream();
        int          owner, e, c;
        txn_t        t;
        logic        terr;
        int          word;
        logic [31:0] exp_rd;
        @(negedge clk);
        drive();
        select(owner);
        e = 2;
        c = 0;
        while (owner >= 0 && c < 400) begin
            @(negedge clk);
            c++;
            t    = (owner == 1) ? q1[0] : q0[0];
            word = int'(t.addr[31:2]);
            terr = (word >= WORDS);
            chk("we_gated", 32'(sram_we & ~sram_ce), 32'd0);
            if (c == e - 1) begin
                chk("ce_access", 32'(sram_ce), 32'(!terr));
                if (!terr) begin
                    chk("pin_we", 32'(sram_we), 32'(t.we));
                    chk("pin_addr", sram_addr, t.addr);
                    chk("pin_sel", 32'(sram_sel), 32'(t.sel));
                    chk("pin_wdata", sram_wdata, t.wdata);
                end
            end else begin
                chk("ce_idle", 32'(sram_ce), 32'd0);
            end
            if (c == e) begin
                ack_log.push_back({m1_ack, m0_ack});
                if (terr)       exp_rd = 32'd0;
                else if (!t.we) exp_rd = ref_mem[word];
                else            exp_rd = hold[owner];
                if (t.we && !terr)
                    for (int b = 0; b < 4; b++)
                        if (t.sel[b]) ref_mem[word][8*b +: 8] = t.wdata[8*b +: 8];
                if (owner == 1) begin
                    chk("ack_own", 32'(m1_ack), 32'd1);
                    chk("ack_other", 32'(m0_ack), 32'd0);
                    chk("err", 32'(m1_err), 32'(terr));
                    chk("err_other", 32'(m0_err), 32'd0);
                    chk("rdata", m1_rdata, exp_rd);
                    chk("rdata_other", m0_rdata, hold[0]);
                    void'(q1.pop_front());
                end else begin
                    chk("ack_own", 32'(m0_ack), 32'd1);
                    chk("ack_other", 32'(m1_ack), 32'd0);
                    chk("err", 32'(m0_err), 32'(terr));
                    chk("err_other", 32'(m1_err), 32'd0);
                    chk("rdata", m0_rdata, exp_rd);
                    chk("rdata_other", m1_rdata, hold[1]);
                    void'(q0.pop_front());
                end
                hold[owner] = exp_rd;
                drive();
                select(owner);
                e += 3;
            end else begin
                chk("no_ack", 32'({m1_ack, m0_ack}), 32'd0);
            end
        end
        chk("stream_done", 32'(owner < 0), 32'd1);
        q0.delete();
        q1.delete();
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ce"}, 32'(sram_ce), 32'd0);
        chk({tag, "_we"}, 32'(sram_we), 32'd0);
        chk({tag, "_addr"}, sram_addr, 32'd0);
        chk({tag, "_sel"}, 32'(sram_sel), 32'd0);
        chk({tag, "_wdata"}, sram_wdata, 32'd0);
        chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
        chk({tag, "_errs"}, 32'({m1_err, m0_err}), 32'd0);
        chk({tag, "_rd0"}, m0_rdata, 32'd0);
        chk({tag, "_rd1"}, m1_rdata, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int  r;
        int  word;
        r = $urandom_range(0, 9);
        if (r == 0)      word = WORDS + $urandom_range(0, 300);
        else if (r == 1) word = WORDS - 1;
        else             word = $urandom_range(0, 15);
        return {word[29:0], 2'($urandom)};
    endfunction

    initial begin
        int n0, n1;
        n_checks = 0;
        n_fail   = 0;
        last_g   = 1;
        hold[0]  = '0;
        hold[1]  = '0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_sel = '0; m1_sel = '0;
        m0_wdata = '0; m1_wdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        mem[4] = 32'hAABBCCDD; ref_mem[4] = 32'hAABBCCDD;
        mem[7] = 32'h11111111; ref_mem[7] = 32'h11111111;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Read after reset.
        push(0, 1'b0, 32'h14, 4'h0, 32'h0);
        run_stream();
        chk("tp_read", m0_rdata, 32'hDEADBEEF);
        chk("tp_read_m1", m1_rdata, 32'd0);

        // Byte-lane write then read back.
        push(1, 1'b1, 32'h10, 4'b0011, 32'h12345678);
        run_stream();
        push(0, 1'b0, 32'h10, 4'h0, 32'h0);
        run_stream();
        chk("tp_byte_write", m0_rdata, 32'hAABB5678);

        // Out-of-range write at word MEM_WORDS.
        push(0, 1'b1, 32'h1080, 4'hF, 32'hCAFEF00D);
        run_stream();
        chk("tp_range_rdata", m0_rdata, 32'd0);

        // sel = 0 write is a normal, harmless access.
        push(1, 1'b1, 32'hC, 4'h0, 32'hFFFFFFFF);
        run_stream();
        push(0, 1'b0, 32'h14, 4'h0, 32'h0);
        push(1, 1'b0, 32'hC, 4'h0, 32'h0);
        run_stream();

        // Reset while a write to word 7 is in ACCESS.
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1C; m0_sel = 4'hF; m0_wdata = 32'h55555555;
        @(posedge clk);
        #2;
        chk("rst_pre_ce", 32'(sram_ce), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        m0_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ack", 32'({m1_ack, m0_ack}), 32'd0);
        end
        chk("rst_word7", mem[7], 32'h11111111);
        rst_n   = 1'b1;
        last_g  = 1;
        hold[0] = '0;
        hold[1] = '0;

        // Tie fairness: both masters keep requesting, 4 accesses each.
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 32'(4 * i), 4'h0, 32'h0);
            push(1, 1'b0, 32'(4 * (i + 8)), 4'h0, 32'h0);
        end
        run_stream();
        chk("tie_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < ack_log.size(); i++)
            chk("tie_order", 32'(ack_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++)
                push(0, 1'($urandom), rand_addr(), 4'($urandom), $urandom);
            for (int k = 0; k < n1; k++)
                push(1, 1'($urandom), rand_addr(), 4'($urandom), $urandom);
            run_stream();
        end
        for (int i = 0; i < 16; i++)
            chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter and sequencer for the single-port `sram` data memory. It shares the memory between the match-action pipeline data port (master 0) and the reconfiguration loader (master 1) using round-robin arbitration. It drives the `sram` control, address and data pins from registers, captures read data, and returns a one-cycle acknowledge to the granted master. Out-of-range accesses are rejected with an error response and never reach the memory.

## Interface
Parameters:
- `MEM_WORDS`, 1056: number of 32-bit words in the attached `sram`. A word index is `addr[31:2]`; valid indices are 0 to `MEM_WORDS`-1.

Ports (clock and reset first):
- `clk` in 1: single clock. Posedge only.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1: access request. Held high, with its qualifiers stable, until the matching ack.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in `ADDR_BUS`: byte address.
- `m0_sel`, `m1_sel` in 4: byte lane enables for writes; bit 3 selects data[31:24].
- `m0_wdata`, `m1_wdata` in `DATA_BUS`: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with ack; 1 = address out of range.
- `m0_rdata`, `m1_rdata` out `DATA_BUS`: read data, valid with ack. Holds its value until that master's next ack.
- `sram_ce`, `sram_we` out 1: memory chip enable and write enable.
- `sram_addr` out `ADDR_BUS`, `sram_sel` out 4, `sram_wdata` out `DATA_BUS`: memory address, byte select and write data.
- `sram_rdata` in `DATA_BUS`: memory read data. The memory's read path is combinational.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: one memory cycle.
  - DONE: ack pulse.
- Transitions:
  - IDLE → ACCESS when any req is sampled high. The winner's we/addr/sel/wdata and an owner bit are latched at that edge.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
  - Requests are evaluated only in IDLE.
- Arbitration:
  - Single request: that master wins.
  - Both requesting: the master not granted last wins.
  - `last_gnt` resets to 1, so master 0 wins the first tie.
  - `last_gnt` updates on every grant, including error grants.
- Range check: at grant, `err` = (`addr[31:2]` ≥ `MEM_WORDS`). On error, ACCESS keeps `sram_ce` = 0, so no write occurs; the owner receives rdata = 0 and err = 1.
- Memory pin behaviour in ACCESS (no error):
  - `sram_ce` = 1.
  - `sram_we` = latched we.
  - addr, sel and wdata driven from the latch.
  - Reads: `sram_rdata` is captured into the owner's rdata register at the edge leaving ACCESS.
  - Writes: the memory commits at the same edge. The owner's rdata is unchanged.
- Memory pins in IDLE and DONE: all `sram_*` outputs = 0, so no spurious write.
- A write with sel = 4'b0000 is a legal no-op: normal ack, err = 0.
- Only the owner's ack/err change; the other master's outputs stay 0 or hold.

## Timing
- Reset values, applied immediately while `rst_n` = 0:
  - state = IDLE, `last_gnt` = 1.
  - All `sram_*` outputs = 0.
  - All ack/err = 0, all rdata = 0.
- Latency: req sampled at edge E0 → ACCESS during cycle E0..E1 → ack high during cycle E1..E2.
- Throughput: at most one access per 3 cycles.
- A requester must drop req, or present its next request, in the cycle after ack. A req still high in IDLE is treated as a new request.
- Reset mid-operation:
  - If `rst_n` falls during ACCESS, `sram_ce` drops at once and no write commits.
  - Any pending transaction is discarded without an ack. Masters re-issue after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The `ADDR_BUS`, `DATA_BUS`, `TRUE`, `FALSE` and `ZERO_WORD` macros come from `def.vh`.
- Add to `def.vh`:
  - state encodings `ARB_IDLE`, `ARB_ACCESS`, `ARB_DONE` (2 bits);
  - `SRAM_WORDS` = 1056, used as the default for `MEM_WORDS`.
- One sub-module, `rr_arb2`: a two-input round-robin picker holding the `last_gnt` register, with inputs req[1:0] and update, and output gnt[1:0] (one-hot).
- The top-level module holds the FSM, the request latch, the range check and the output registers.

## Test plan
- Read after reset: m0 reads word 5 holding 32'hDEADBEEF. Expect m0_ack 2 cycles after req, m0_rdata = 32'hDEADBEEF, m0_err = 0; m1 outputs stay 0.
- Byte write: m1 writes addr 0x10 with sel 4'b0011 and wdata 32'h12345678 over 32'hAABBCCDD. A later read returns 32'hAABB5678. sram_we is high only in ACCESS.
- Tie fairness: m0 and m1 both request continuously, 4 accesses each. Grants alternate m0, m1, m0, m1, and acks are spaced 3 cycles apart.
- Range error: m0 writes addr 0x1080 (word 1056). Expect m0_ack with m0_err = 1 and m0_rdata = 0, sram_ce never asserted, and memory unchanged.
- Reset in ACCESS: assert rst_n low mid-cycle during a write to word 7. Expect all outputs 0 immediately, no ack, and word 7 unchanged.
